// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the CPU read port.
// Finds the receiver's byte-complete strobe, buffers bytes in a circular FIFO, and raises overflow/irq flags.
module uart_rx_fifo #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_status,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_enable,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              irq
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic              s1_q, s2_q, s3_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              irq_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic push_req, do_push, do_pop, drop;

  // rx_status comes from the slower UART clock domain. Flops reset high so a strobe already high at reset release gives no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= rx_status;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign push_req = s2_q & ~s3_q;

  // A pop on a full FIFO frees the slot that a simultaneous push then takes.
  always_comb begin
    do_pop     = pop & (count_q != '0);
    do_push    = push_req & (~full | do_pop);
    drop       = push_req & full & ~do_pop;
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{ADDR_W{1'b0}}, do_push} - {{ADDR_W{1'b0}}, do_pop};
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH[ADDR_W:0]);
  assign rx_enable = ~full;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign irq       = irq_q;
  assign dout      = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model compared every cycle, plus directed literal checks.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_status = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_enable;
  logic       pop = 1'b0;
  logic [7:0] dout;
  logic       empty, full;
  logic [3:0] count;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       irq;

  int checks = 0;
  int failures = 0;

  uart_rx_fifo #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .rx_status(rx_status), .rx_data(rx_data),
    .rx_enable(rx_enable), .pop(pop), .dout(dout), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .clr_overflow(clr_overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue; a rising rx_status seen at one edge pushes two edges later.
  logic [7:0] mq[$];
  bit m_ov = 0, m_irq = 0, m_prev = 1, rise_d1 = 0, rise_d2 = 0, model_on = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ov = 0; m_irq = 0; m_prev = 1; rise_d1 = 0; rise_d2 = 0;
      model_on = 1;
    end else begin
      bit was_full, popped, dropped;
      was_full = (mq.size() == 8);
      popped   = pop && (mq.size() > 0);
      dropped  = 0;
      if (popped) void'(mq.pop_front());
      if (rise_d2) begin
        if (!was_full || popped) mq.push_back(rx_data);
        else dropped = 1;
      end
      if (dropped) m_ov = 1;
      else if (clr_overflow) m_ov = 0;
      m_irq   = (mq.size() != 0);
      rise_d2 = rise_d1;
      rise_d1 = rx_status && !m_prev;
      m_prev  = rx_status;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      cmp("count", 32'(count), 32'(mq.size()));
      cmp("empty", 32'(empty), 32'(mq.size() == 0));
      cmp("full", 32'(full), 32'(mq.size() == 8));
      cmp("rx_enable", 32'(rx_enable), 32'(mq.size() != 8));
      cmp("dout", 32'(dout), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      cmp("overflow", 32'(overflow), 32'(m_ov));
      cmp("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int hi);
    rx_data = d;
    rx_status = 1'b1;
    tick(hi);
    rx_status = 1'b0;
    tick(4);
  endtask

  task automatic pop1();
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    tick(1);
    cmp("rst_count", 32'(count), 32'h0);
    cmp("rst_empty", 32'(empty), 32'h1);
    cmp("rst_irq", 32'(irq), 32'h0);

    // 1: long strobe gives exactly one push, visible after the third edge
    rx_data = 8'hA5;
    rx_status = 1'b1;
    tick(2);
    cmp("t1_count_early", 32'(count), 32'h0);
    tick(1);
    cmp("t1_count", 32'(count), 32'h1);
    cmp("t1_dout", 32'(dout), 32'hA5);
    cmp("t1_empty", 32'(empty), 32'h0);
    cmp("t1_irq", 32'(irq), 32'h1);
    tick(197);
    rx_status = 1'b0;
    tick(4);
    cmp("t1_count_held", 32'(count), 32'h1);
    pop1();

    // 2: fill, overflow drop, drain in order
    for (int i = 1; i <= 8; i++) send(8'(i), 3);
    cmp("t2_full", 32'(full), 32'h1);
    cmp("t2_rx_enable", 32'(rx_enable), 32'h0);
    cmp("t2_count", 32'(count), 32'h8);
    send(8'hFF, 3);
    cmp("t2_overflow", 32'(overflow), 32'h1);
    cmp("t2_count_drop", 32'(count), 32'h8);
    for (int i = 1; i <= 8; i++) begin
      cmp("t2_pop_dout", 32'(dout), 32'(i));
      pop1();
    end
    cmp("t2_empty", 32'(empty), 32'h1);
    cmp("t2_dout0", 32'(dout), 32'h0);
    cmp("t2_irq", 32'(irq), 32'h0);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    cmp("t2_ov_clr", 32'(overflow), 32'h0);

    // 3: pointer wrap
    for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), 2);
    for (int i = 0; i < 6; i++) pop1();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 2);
    for (int i = 0; i < 5; i++) begin
      cmp("t3_pop_dout", 32'(dout), 32'h10 + 32'(i));
      pop1();
    end
    cmp("t3_count", 32'(count), 32'h0);

    // 4: push and pop on the same edge while full
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 2);
    rx_data = 8'h77;
    rx_status = 1'b1;
    tick(2);
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    rx_status = 1'b0;
    tick(3);
    cmp("t4_count", 32'(count), 32'h8);
    cmp("t4_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 7; i++) pop1();
    cmp("t4_last", 32'(dout), 32'h77);
    pop1();

    // 5: pop on empty, then clear colliding with a drop
    pop1();
    cmp("t5_count", 32'(count), 32'h0);
    cmp("t5_dout", 32'(dout), 32'h0);
    cmp("t5_ov", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 2);
    rx_data = 8'hEE;
    rx_status = 1'b1;
    tick(2);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    rx_status = 1'b0;
    tick(2);
    cmp("t5_ov_set_wins", 32'(overflow), 32'h1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    cmp("t5_ov_cleared", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) pop1();

    // 6: reset flush with rx_status held high across release
    for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 2);
    cmp("t6_pre_count", 32'(count), 32'h3);
    rx_data = 8'h99;
    rx_status = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    cmp("t6_count", 32'(count), 32'h0);
    cmp("t6_empty", 32'(empty), 32'h1);
    rx_status = 1'b0;
    tick(3);
    cmp("t6_no_push", 32'(count), 32'h0);
    send(8'h5A, 3);
    cmp("t6_repush", 32'(count), 32'h1);
    cmp("t6_dout", 32'(dout), 32'h5A);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
